// File: rtl/dds_pkg.sv
// Shared constants, state type and bench helper for the DDS block.
`ifndef DDS_PKG_SV
`define DDS_PKG_SV

`define MHZ(x) ((x) * 1_000_000)

package dds_pkg;

    localparam int unsigned DATA_LEN_DEF    = 8;
    localparam int unsigned ROWS_BASE_2_DEF = 10;
    localparam int unsigned ACC_W           = 32;

    // round(2^32 / 360): one degree expressed as accumulator phase
    localparam logic [ACC_W-1:0] DEG_TO_PHASE = 32'd11930465;
    localparam logic [8:0]       MAX_PHASE    = 9'd359;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

`endif

// File: rtl/dds_wave_ram.sv
// Simple dual-port waveform RAM: one write port, one registered read port.
module dds_wave_ram #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 10
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Table write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Synchronous read; a same-address write in this cycle yields the old word
    always_ff @(posedge clk_i) begin
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dds.sv
// Direct digital synthesizer: phase accumulator + phase offset driving a
// RAM waveform table, 8-bit sample output.
module dds
    import dds_pkg::*;
#(
    parameter int unsigned DATA_LEN    = DATA_LEN_DEF,
    parameter int unsigned ROWS_BASE_2 = ROWS_BASE_2_DEF
) (
    input  logic                   src_clk,
    input  logic                   rst,
    input  logic                   set_phase,
    input  logic [8:0]             phase,
    input  logic                   set_freq,
    input  logic [31:0]            freq,
    input  logic [DATA_LEN-1:0]    data_wr,
    input  logic [ROWS_BASE_2-1:0] addr_wr,
    input  logic                   we,
    output logic [7:0]             sinwave
);

    state_e                 state_q, state_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [ACC_W-1:0]       ftw_q, ftw_d;
    logic [ACC_W-1:0]       poff_q, poff_d;
    logic [ROWS_BASE_2-1:0] addr_q, addr_d;
    logic [ACC_W-1:0]       lookup;
    logic [DATA_LEN-1:0]    rd_word;
    logic                   ram_we;

    // Reset dominates, so table writes are blocked while rst is high
    assign ram_we = we & ~rst;

    dds_wave_ram #(
        .DW (DATA_LEN),
        .AW (ROWS_BASE_2)
    ) u_ram (
        .clk_i   (src_clk),
        .we_i    (ram_we),
        .waddr_i (addr_wr),
        .wdata_i (data_wr),
        .raddr_i (addr_q),
        .rdata_o (rd_word)
    );

    // Next-state for FSM, accumulator, tuning word, phase offset and address
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ftw_d   = ftw_q;
        poff_d  = poff_q;
        if (state_q == RUN) begin
            acc_d = acc_q + ftw_q;
        end
        if (set_freq) begin
            ftw_d   = freq;
            state_d = (freq != '0) ? RUN : IDLE;
        end
        if (set_phase && (phase <= MAX_PHASE)) begin
            poff_d = {23'd0, phase} * DEG_TO_PHASE;
        end
        lookup = acc_q + poff_q;
        addr_d = lookup[ACC_W-1 -: ROWS_BASE_2];
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge src_clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ftw_q   <= '0;
            poff_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ftw_q   <= ftw_d;
            poff_q  <= poff_d;
            addr_q  <= addr_d;
        end
    end

    // Output the table word MSBs only while running
    always_comb begin
        sinwave = '0;
        if (state_q == RUN) begin
            sinwave = rd_word[DATA_LEN-1 -: 8];
        end
    end

endmodule

// File: tb/tb_dds.sv
// Directed self-checking bench for the dds block.
module tb_dds;
    import dds_pkg::*;

    logic        src_clk = 1'b0;
    logic        rst = 1'b1;
    logic        set_phase = 1'b0;
    logic [8:0]  phase = '0;
    logic        set_freq = 1'b0;
    logic [31:0] freq = '0;
    logic [7:0]  data_wr = '0;
    logic [9:0]  addr_wr = '0;
    logic        we = 1'b0;
    logic [7:0]  sinwave;

    int unsigned errs = 0;
    int unsigned checks = 0;

    dds #(
        .DATA_LEN    (8),
        .ROWS_BASE_2 (10)
    ) dut (
        .src_clk   (src_clk),
        .rst       (rst),
        .set_phase (set_phase),
        .phase     (phase),
        .set_freq  (set_freq),
        .freq      (freq),
        .data_wr   (data_wr),
        .addr_wr   (addr_wr),
        .we        (we),
        .sinwave   (sinwave)
    );

    always #5 src_clk = ~src_clk;

    task automatic tick(input int unsigned n = 1);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge src_clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic strobe_freq(input logic [31:0] f);
        set_freq = 1'b1;
        freq     = f;
        tick();
        set_freq = 1'b0;
    endtask

    task automatic strobe_phase(input logic [8:0] p);
        set_phase = 1'b1;
        phase     = p;
        tick();
        set_phase = 1'b0;
    endtask

    task automatic write_word(input logic [9:0] a, input logic [7:0] d);
        we      = 1'b1;
        addr_wr = a;
        data_wr = d;
        tick();
        we      = 1'b0;
    endtask

    initial begin
        logic [9:0] a;

        // Plain reset
        tick(2);
        rst = 1'b0;
        chk("reset_out", sinwave, 8'h00);

        write_word(10'd0, 8'h22);
        write_word(10'd5, 8'h11);

        // Reset with every other input active: nothing may take effect
        rst       = 1'b1;
        we        = 1'b1;
        addr_wr   = 10'd5;
        data_wr   = 8'hAA;
        set_freq  = 1'b1;
        freq      = 32'h0040_0000;
        set_phase = 1'b1;
        phase     = 9'd90;
        tick();
        chk("rst_busy_0", sinwave, 8'h00);
        tick();
        chk("rst_busy_1", sinwave, 8'h00);
        rst = 1'b0; we = 1'b0; set_freq = 1'b0; set_phase = 1'b0;
        tick(4);
        chk("idle_after_rst", sinwave, 8'h00);

        // Simultaneous phase (2 deg -> index 5) and freq=1; mem[5] kept 0x11
        set_phase = 1'b1;
        phase     = 9'd2;
        strobe_freq(32'd1);
        set_phase = 1'b0;
        tick(2);
        chk("no_write_in_rst", sinwave, 8'h11);

        // Ramp table load
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int unsigned k = 0; k < 1024; k++) begin
            a = 10'(k);
            write_word(a, a[7:0]);
        end

        // One entry per clock: 0,1,..,255,0,.. through the 1023->0 wrap
        strobe_freq(32'h0040_0000);
        tick();
        for (int unsigned k = 0; k < 1030; k++) begin
            tick();
            chk("ramp", sinwave, 8'(k));
        end

        // Phase-continuous retune to two entries per clock
        strobe_freq(32'h0080_0000);
        chk("retune_0", sinwave, 8'd6);
        tick();
        chk("retune_1", sinwave, 8'd7);
        tick();
        chk("retune_2", sinwave, 8'd8);
        tick();
        chk("retune_3", sinwave, 8'd10);
        tick();
        chk("retune_4", sinwave, 8'd12);

        // Phase offset with freq=0 stays idle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_phase = 1'b1;
        phase     = 9'd90;
        strobe_freq(32'd0);
        set_phase = 1'b0;
        tick(3);
        chk("phase90_idle", sinwave, 8'h00);

        strobe_freq(32'd1);
        tick(2);
        chk("phase90_ramp", sinwave, 8'h00);

        // Reload with mem[k]=k>>2 while running
        for (int unsigned k = 0; k < 1024; k++) begin
            a = 10'(k);
            write_word(a, a[9:2]);
        end
        tick(2);
        chk("phase90_quarter", sinwave, 8'd64);

        strobe_phase(9'd180);
        tick(2);
        chk("phase180", sinwave, 8'd128);
        strobe_phase(9'd0);
        tick(2);
        chk("phase0", sinwave, 8'd0);
        strobe_phase(9'd359);
        tick(2);
        chk("phase359", sinwave, 8'd255);
        strobe_phase(9'd400);
        tick(2);
        chk("phase400_ignored", sinwave, 8'd255);
        strobe_phase(9'd360);
        tick(2);
        chk("phase360_ignored", sinwave, 8'd255);

        // Stop and resume from the held accumulator (4 entries per clock)
        rst = 1'b1;
        tick();
        rst = 1'b0;
        strobe_freq(32'h0100_0000);
        tick(10);
        chk("run_before_stop", sinwave, 8'd8);
        strobe_freq(32'd0);
        chk("stop_0", sinwave, 8'd0);
        tick(2);
        chk("stop_held", sinwave, 8'd0);
        strobe_freq(32'h0100_0000);
        tick(2);
        chk("resume_0", sinwave, 8'd11);
        tick();
        chk("resume_1", sinwave, 8'd12);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
